mips_run_monitor: RTL and testbench

- Synthesizable, parametrised run controller for mips_core; replaces a fixed-time reset/finish bench sequence.
- Generates the core's reset sequence and enforces a cycle budget.
- Detects a halt instruction on the retire stream and counts cycles and retired instructions.
- Optionally captures a retirement trace for the bench or a debug port to read.
- Sits beside mips_core; the testbench only drives clock, reset and start.

---
 rtl/mips_run_pkg.sv | 26 ++
 rtl/mips_run_monitor_if.sv | 25 ++
 rtl/mips_trace_ring.sv | 68 ++++++
 rtl/mips_run_monitor.sv | 161 ++++++++++++++++
 tb/tb_mips_run_monitor.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_run_pkg.sv
// Shared types and constants for the mips_core run monitor.
// Optional trace storage is enabled with MIPS_RUN_TRACE_EN.
package mips_run_pkg;

    localparam int CNT_W = 32;
    localparam logic [31:0] HALT_WORD_DEF = 32'h0000000C;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        DONE
    } run_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mips_run_monitor_if.sv
// Retire stream and trace read port between mips_core side and monitor.
// master = core/bench side, slave = run monitor.
interface mips_run_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              retire_valid;
    logic [ADDR_W-1:0] retire_pc;
    logic [DATA_W-1:0] retire_instr;
    logic              trace_rd;
    logic [ADDR_W-1:0] trace_pc;
    logic [DATA_W-1:0] trace_instr;
    logic              trace_empty;
    logic              trace_ovf;

    modport master (
        output retire_valid, retire_pc, retire_instr, trace_rd,
        input  trace_pc, trace_instr, trace_empty, trace_ovf
    );

    modport slave (
        input  retire_valid, retire_pc, retire_instr, trace_rd,
        output trace_pc, trace_instr, trace_empty, trace_ovf
    );
endinterface

// File: rtl/mips_trace_ring.sv
// Circular trace buffer; a push when full drops the oldest entry.
// Used by mips_run_monitor only when MIPS_RUN_TRACE_EN is defined.
module mips_trace_ring #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         ovf_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW:0]   cnt_q;
    logic          ovf_q;
    logic          full;
    logic          pop_ok;
    logic          adv;

    assign full    = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign pop_ok  = pop_i && !empty_o;
    // Head moves on a real pop or when a full push evicts the oldest.
    assign adv     = pop_ok || (push_i && full);
    assign rdata_o = empty_o ? '0 : mem_q[head_q];
    assign ovf_o   = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= wdata_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (adv) begin
                head_q <= head_q + PW'(1);
            end
            if (push_i && full && !pop_i) begin
                ovf_q <= 1'b1;
            end
            if (push_i && !full && !pop_ok) begin
                cnt_q <= cnt_q + (PW+1)'(1);
            end else if (pop_ok && !push_i) begin
                cnt_q <= cnt_q - (PW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/mips_run_monitor.sv
// Run controller for mips_core: reset sequencing, halt/budget, counters.
// Define MIPS_RUN_TRACE_EN to include the retirement trace buffer.
module mips_run_monitor
    import mips_run_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 16,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF),
    parameter int TRACE_DEPTH  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    mips_run_if.slave        bus
);
    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             rst_q, rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             halt_q, halt_d;
    logic             to_q, to_d;
    logic             clr;
    logic             push;
    logic             is_halt;

    assign is_halt = bus.retire_valid && (bus.retire_instr == HALT_WORD);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        ret_d   = ret_q;
        rst_d   = rst_q;
        done_d  = done_q;
        halt_d  = halt_q;
        to_d    = to_q;
        clr     = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = HOLD;
                    hold_d  = CNT_W'(RESET_CYCLES);
                    cyc_d   = '0;
                    ret_d   = '0;
                    rst_d   = 1'b1;
                    done_d  = 1'b0;
                    halt_d  = 1'b0;
                    to_d    = 1'b0;
                    clr     = 1'b1;
                end
            end
            HOLD: begin
                rst_d = 1'b1;
                if (hold_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    hold_d  = '0;
                    rst_d   = 1'b0;
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            RUN: begin
                cyc_d = sat_inc(cyc_q);
                if (bus.retire_valid) begin
                    ret_d = sat_inc(ret_q);
                    push  = 1'b1;
                end
                // Halt wins over a budget expiry on the same cycle.
                if (is_halt) begin
                    state_d = DONE;
                    rst_d   = 1'b1;
                    done_d  = 1'b1;
                    halt_d  = 1'b1;
                end else if (MAX_CYCLES != 0 &&
                             cyc_d == CNT_W'(MAX_CYCLES)) begin
                    state_d = DONE;
                    rst_d   = 1'b1;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end
            end
        endcase
        busy_d = (state_d == HOLD) || (state_d == RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cyc_q   <= '0;
            ret_q   <= '0;
            rst_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            halt_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            halt_q  <= halt_d;
            to_q    <= to_d;
        end
    end

    assign core_rst     = rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign halted       = halt_q;
    assign timeout      = to_q;
    assign cycle_count  = cyc_q;
    assign retire_count = ret_q;

`ifdef MIPS_RUN_TRACE_EN
    logic [ADDR_W+DATA_W-1:0] rd_w;

    mips_trace_ring #(
        .DEPTH (TRACE_DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_ring (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (bus.trace_rd),
        .wdata_i ({bus.retire_pc, bus.retire_instr}),
        .rdata_o (rd_w),
        .empty_o (bus.trace_empty),
        .ovf_o   (bus.trace_ovf)
    );

    assign bus.trace_pc    = rd_w[ADDR_W+DATA_W-1:DATA_W];
    assign bus.trace_instr = rd_w[DATA_W-1:0];
`else
    localparam int unused_trace_depth = TRACE_DEPTH;
    logic unused_trace;

    assign unused_trace    = ^{bus.trace_rd, bus.retire_pc, clr, push};
    assign bus.trace_empty = 1'b1;
    assign bus.trace_ovf   = 1'b0;
    assign bus.trace_pc    = '0;
    assign bus.trace_instr = '0;
`endif
endmodule

// File: tb/tb_mips_run_monitor.sv
// Scoreboard bench for mips_run_monitor with a queue-level reference model.
// Trace expectations follow MIPS_RUN_TRACE_EN when it is defined.
`timescale 1ns/1ps
module tb_mips_run_monitor;
    import mips_run_pkg::*;

    localparam int MAXC  = 16;
    localparam int RSTC  = 2;
    localparam int DEPTH = 8;
    localparam logic [31:0] HALT = 32'h0000000C;
`ifdef MIPS_RUN_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        core_rst, busy, done, halted, timeout;
    logic [31:0] cycle_count, retire_count;

    mips_run_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mips_run_monitor #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .RESET_CYCLES (RSTC),
        .MAX_CYCLES   (MAXC),
        .HALT_WORD    (HALT),
        .TRACE_DEPTH  (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .halted       (halted),
        .timeout      (timeout),
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
        .bus          (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          h;
        bit          t;
        int unsigned c;
        int unsigned r;
    } exp_t;

    int           vecs = 0;
    int           miss = 0;
    exp_t         sb[$];
    trace_entry_t tq[$];
    bit           t_ovf = 1'b0;
    bit           sv[32];
    logic [31:0]  spc[32];
    logic [31:0]  sin[32];
    bit           srd[32];
    int           stray;
    exp_t         cur;
    logic         done_p = 1'b0;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, want %0h", n, act, exp);
        end
    endtask

    task automatic chk_trace(input string n);
        trace_entry_t f;
        logic         e;
        f = '0;
        e = 1'b1;
        if (TR && tq.size() > 0) begin
            f = tq[0];
            e = 1'b0;
        end
        chk({n, ".tr_empty"}, bus.trace_empty, e);
        chk({n, ".tr_pc"}, bus.trace_pc, f.pc);
        chk({n, ".tr_instr"}, bus.trace_instr, f.instr);
        chk({n, ".tr_ovf"}, bus.trace_ovf, TR & t_ovf);
    endtask

    // Trace model: read takes the oldest, a ninth entry drops the oldest.
    task automatic m_step(input bit rd, input bit v,
                          input logic [31:0] pc, input logic [31:0] in);
        if (rd && tq.size() > 0) void'(tq.pop_front());
        if (v) begin
            tq.push_back('{pc: pc, instr: in});
            if (tq.size() > DEPTH) begin
                void'(tq.pop_front());
                t_ovf = 1'b1;
            end
        end
    endtask

    function automatic exp_t model_run();
        exp_t e;
        e = '{0, 0, 0, 0};
        for (int k = 1; k <= MAXC; k++) begin
            e.c = k;
            if (sv[k-1]) e.r++;
            if (sv[k-1] && sin[k-1] == HALT) begin
                e.h = 1'b1;
                break;
            end
            if (k == MAXC) begin
                e.t = 1'b1;
                break;
            end
        end
        return e;
    endfunction

    task automatic gen_run(input int hp, input int pct, input int rdpct,
                           input logic [31:0] base);
        for (int i = 0; i < 32; i++) begin
            sv[i]  = $urandom_range(0, 99) < pct;
            spc[i] = base + 32'(4 * i);
            sin[i] = $urandom;
            if (sin[i] == HALT) sin[i] = sin[i] ^ 32'h1;
            srd[i] = $urandom_range(0, 99) < rdpct;
        end
        if (hp >= 1 && hp <= 32) begin
            sv[hp-1]  = 1'b1;
            sin[hp-1] = HALT;
        end
        stray = -1;
    endtask

    task automatic begin_run(input string n);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tq.delete();
        t_ovf = 1'b0;
        chk({n, ".hold1_busy"}, busy, 1);
        chk({n, ".hold1_rst"}, core_rst, 1);
        chk({n, ".hold1_done"}, done, 0);
        chk_trace({n, ".cleared"});
        @(negedge clock);
        chk({n, ".hold2_rst"}, core_rst, 1);
        @(negedge clock);
        chk({n, ".run_rst"}, core_rst, 0);
        chk({n, ".run_busy"}, busy, 1);
        chk({n, ".run_cyc0"}, cycle_count, 0);
    endtask

    task automatic do_run(input string n, input int nread);
        int nr;
        cur = model_run();
        sb.push_back(cur);
        begin_run(n);
        for (int i = 0; i < int'(cur.c); i++) begin
            chk_trace({n, ".run"});
            bus.retire_valid = sv[i];
            bus.retire_pc    = spc[i];
            bus.retire_instr = sin[i];
            bus.trace_rd     = srd[i];
            start            = (i == stray);
            m_step(srd[i], sv[i], spc[i], sin[i]);
            @(negedge clock);
        end
        bus.retire_valid = 1'b0;
        bus.trace_rd     = 1'b0;
        start            = 1'b0;
        chk({n, ".done"}, done, 1);
        chk({n, ".done_rst"}, core_rst, 1);
        chk({n, ".done_busy"}, busy, 0);
        nr = (nread < 0) ? $urandom_range(0, tq.size() + 2) : nread;
        for (int k = 0; k < nr; k++) begin
            chk_trace({n, ".read"});
            bus.trace_rd = 1'b1;
            m_step(1'b1, 1'b0, '0, '0);
            @(negedge clock);
        end
        bus.trace_rd = 1'b0;
        chk_trace({n, ".after_read"});
        chk({n, ".frozen_cyc"}, cycle_count, cur.c);
        chk({n, ".frozen_ret"}, retire_count, cur.r);
    endtask

    always @(negedge clock) begin
        if (done && !done_p) begin
            if (sb.size() == 0) begin
                vecs++;
                miss++;
                $display("FAIL sb.unexpected: done=1, want no run end");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb.halted", halted, e.h);
                chk("sb.timeout", timeout, e.t);
                chk("sb.cycle_count", cycle_count, e.c);
                chk("sb.retire_count", retire_count, e.r);
            end
        end
        done_p = done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.retire_valid = 1'b0;
        bus.retire_pc    = '0;
        bus.retire_instr = '0;
        bus.trace_rd     = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("idle.core_rst", core_rst, 1);
            chk("idle.busy", busy, 0);
            chk("idle.done", done, 0);
            chk("idle.cyc", cycle_count, 0);
            chk_trace("idle");
        end

        gen_run(0, 100, 0, 32'h400);
        do_run("timeout", 0);

        gen_run(4, 100, 0, 32'h0);
        do_run("halt4", 5);

        gen_run(10, 100, 0, 32'h1000);
        do_run("ovf10", 8);

        gen_run(16, 100, 0, 32'h2000);
        do_run("both16", -1);

        gen_run(0, 100, 0, 32'h100);
        begin_run("midrst");
        for (int i = 0; i < 5; i++) begin
            bus.retire_valid = sv[i];
            bus.retire_pc    = spc[i];
            bus.retire_instr = sin[i];
            @(negedge clock);
        end
        chk("midrst.cyc5", cycle_count, 5);
        reset = 1'b0;
        #1;
        chk("midrst.core_rst", core_rst, 1);
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.cyc", cycle_count, 0);
        chk("midrst.ret", retire_count, 0);
        chk("midrst.tr_empty", bus.trace_empty, 1);
        chk("midrst.tr_ovf", bus.trace_ovf, 0);
        bus.retire_valid = 1'b0;
        tq.delete();
        t_ovf = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst.idle_busy", busy, 0);

        for (int r = 0; r < 40; r++) begin
            gen_run($urandom_range(1, 24), $urandom_range(20, 100),
                    $urandom_range(0, 40), $urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 3) == 0) stray = $urandom_range(0, 15);
            do_run($sformatf("rnd%0d", r), -1);
        end

        @(negedge clock);
        chk("sb.pending", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
